// File: rtl/vmem_seq.sv
// vmem_seq: sequences one vector memory op into LANES scalar data-memory
// accesses. Stores take one write per lane; loads issue one read per lane,
// then capture the last returning word in a drain cycle.
// Optional build macro: VMEM_SEQ_STRIDE_EN (use the stride port as the
// per-lane address step; otherwise the step is DW/8 bytes).

// Per-lane storage: latched store word and assembled load word.
module vmem_seq_lane #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          latchEn,
  input  logic [DW-1:0] wIn,
  input  logic          capEn,
  input  logic [DW-1:0] capData,
  output logic [DW-1:0] wOut,
  output logic [DW-1:0] rOut
);

  // Store word latched at accept; load word captured when its data returns.
  always_ff @(posedge clk) begin
    if (reset) begin
      wOut <= '0;
      rOut <= '0;
    end else begin
      if (latchEn) wOut <= wIn;
      if (capEn)   rOut <= capData;
    end
  end

endmodule

module vmem_seq #(
  parameter int LANES = 4,
  parameter int DW    = 32,
  parameter int AW    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                vload,
  input  logic                vstore,
  input  logic [AW-1:0]       base,
  input  logic [AW-1:0]       stride,
  input  logic [LANES*DW-1:0] wvec,
  input  logic [DW-1:0]       mem_rdata,
  output logic [AW-1:0]       mem_addr,
  output logic                mem_we,
  output logic [DW-1:0]       mem_wdata,
  output logic                stall,
  output logic                done,
  output logic [LANES*DW-1:0] rvec
);

  localparam int CW = $clog2(LANES + 1);
  localparam int LW = $clog2(LANES);

  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, DONE} state_t;

  state_t               state, nextState;
  logic [CW-1:0]        cnt;
  logic [AW-1:0]        addrReg;
  logic                 isStore;
  logic [AW-1:0]        strideEff;
  logic                 accept;
  logic                 lastLane;
  logic                 capValid;
  logic [LW-1:0]        capLane;
  logic [LW-1:0]        curLane;
  logic [LANES-1:0][DW-1:0] wIn, wLat, rLanes;

`ifdef VMEM_SEQ_STRIDE_EN
  logic [AW-1:0] strideLat;
  assign strideEff = strideLat;
`else
  // Stride port is present for interface compatibility only.
  logic unusedStride;
  assign unusedStride = ^stride;
  assign strideEff    = AW'(DW / 8);
`endif

  assign accept   = (state == IDLE) && req && (vload | vstore);
  assign lastLane = (cnt == CW'(LANES - 1));
  assign curLane  = cnt[LW-1:0];
  // Read data lags the address by one cycle, so the lane being captured
  // is one behind the counter; in DRAIN the counter sits at LANES.
  assign capLane  = LW'(cnt - CW'(1));
  assign capValid = !isStore &&
                    (((state == ACCESS) && (cnt != '0)) || (state == DRAIN));
  assign wIn      = wvec;
  assign rvec     = rLanes;

  for (genvar i = 0; i < LANES; i++) begin : gLane
    vmem_seq_lane #(.DW(DW)) uLane (
      .clk     (clk),
      .reset   (reset),
      .latchEn (accept),
      .wIn     (wIn[i]),
      .capEn   (capValid && (capLane == LW'(i))),
      .capData (mem_rdata),
      .wOut    (wLat[i]),
      .rOut    (rLanes[i])
    );
  end

  // Memory-side outputs; a write is suppressed as soon as reset is raised.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (state == ACCESS) begin
      mem_addr = addrReg;
      if (isStore) begin
        mem_we    = !reset;
        mem_wdata = wLat[curLane];
      end
    end
  end

  // State, lane counter, running address and op latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      addrReg <= '0;
      isStore <= 1'b0;
`ifdef VMEM_SEQ_STRIDE_EN
      strideLat <= '0;
`endif
    end else begin
      state <= nextState;
      if (accept) begin
        cnt     <= '0;
        addrReg <= base;
        isStore <= vstore;
`ifdef VMEM_SEQ_STRIDE_EN
        strideLat <= stride;
`endif
      end else if (state == ACCESS) begin
        cnt     <= cnt + CW'(1);
        addrReg <= addrReg + strideEff;
      end
    end
  end

  // Next state plus stall/done; DONE deliberately ignores req.
  always_comb begin
    nextState = state;
    stall     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall     = 1'b1;
          nextState = ACCESS;
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (lastLane) nextState = isStore ? DONE : DRAIN;
      end
      DRAIN: begin
        stall     = 1'b1;
        nextState = DONE;
      end
      DONE: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vmem_seq.sv
// Directed bench for vmem_seq (LANES=4, DW=32, AW=32): table of single ops
// plus hand-written reset-abort and back-to-back sequences.
module tb_vmem_seq;

  logic         clk, reset, req, vload, vstore;
  logic [31:0]  base, stride, mem_rdata, mem_addr, mem_wdata;
  logic [127:0] wvec, rvec;
  logic         mem_we, stall, done;

  int tests  = 0;
  int fails  = 0;
  int wrCount = 0;

  vmem_seq #(.LANES(4), .DW(32), .AW(32)) dut (
    .clk(clk), .reset(reset), .req(req), .vload(vload), .vstore(vstore),
    .base(base), .stride(stride), .wvec(wvec), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .stall(stall), .done(done), .rvec(rvec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] romData(input logic [31:0] a);
    case (a)
      32'h200: romData = 32'h11;
      32'h204: romData = 32'h22;
      32'h208: romData = 32'h33;
      32'h20C: romData = 32'h44;
`ifdef VMEM_SEQ_STRIDE_EN
      32'hFFFF_FFF0: romData = 32'h55;
      32'h0:         romData = 32'h66;
      32'h10:        romData = 32'h77;
      32'h20:        romData = 32'h88;
`else
      32'hFFFF_FFF8: romData = 32'h55;
      32'hFFFF_FFFC: romData = 32'h66;
      32'h0:         romData = 32'h77;
      32'h4:         romData = 32'h88;
`endif
      default: romData = 32'hE0E0_0000 | a[15:0];
    endcase
  endfunction

  // Data memory: one-cycle read latency, write counter.
  always @(posedge clk) begin
    mem_rdata <= romData(mem_addr);
    if (mem_we) wrCount <= wrCount + 1;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         ld, st;
    logic [31:0]  base, stride;
    logic [127:0] wv;
    logic [127:0] expAddr;
    logic         expWe;
    logic [127:0] expRv;
    int           expLat;
  } vec_t;

  vec_t tv[4];
  localparam logic [127:0] LDVEC = {32'h44, 32'h33, 32'h22, 32'h11};
  localparam logic [127:0] WRAPV = {32'h88, 32'h77, 32'h66, 32'h55};
  localparam logic [127:0] STV   = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};

  int doneAt;
  logic [31:0] lane;

  initial begin
    tv[0] = '{1'b0, 1'b1, 32'h100, 32'h4, STV,
              {32'h10C, 32'h108, 32'h104, 32'h100}, 1'b1, 128'h0, 5};
    tv[1] = '{1'b1, 1'b0, 32'h200, 32'h4, 128'h0,
              {32'h20C, 32'h208, 32'h204, 32'h200}, 1'b0, LDVEC, 6};
    tv[2] = '{1'b1, 1'b1, 32'h300, 32'h4, ~STV,
              {32'h30C, 32'h308, 32'h304, 32'h300}, 1'b1, LDVEC, 5};
`ifdef VMEM_SEQ_STRIDE_EN
    tv[3] = '{1'b1, 1'b0, 32'hFFFF_FFF0, 32'h10, 128'h0,
              {32'h20, 32'h10, 32'h0, 32'hFFFF_FFF0}, 1'b0, WRAPV, 6};
`else
    tv[3] = '{1'b1, 1'b0, 32'hFFFF_FFF8, 32'h10, 128'h0,
              {32'h4, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFF8}, 1'b0, WRAPV, 6};
`endif

    reset = 1'b1; req = 1'b0; vload = 1'b0; vstore = 1'b0;
    base = '0; stride = '0; wvec = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_done", done, 0);
    chk("rst_stall", stall, 0);
    chk("rst_rvec", rvec, 0);
    req = 1'b1; vstore = 1'b1; #1;
    chk("rst_stall_accept", stall, 1);
    req = 1'b0; vstore = 1'b0; #1;
    chk("rst_stall_noreq", stall, 0);
    @(negedge clk);
    reset = 1'b0;

    // Table of single ops; operands are scrambled right after accept.
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      req = 1'b1; vload = tv[v].ld; vstore = tv[v].st;
      base = tv[v].base; stride = tv[v].stride; wvec = tv[v].wv;
      #1;
      chk("stall_accept", stall, 1);
      @(posedge clk); #1;
      req = 1'b0; vload = 1'b0; vstore = 1'b0;
      base = 32'hDEAD_BEEF; stride = 32'h7; wvec = {4{32'h0BAD_F00D}};
      doneAt = 0;
      for (int c = 1; c <= 12 && doneAt == 0; c++) begin
        @(negedge clk);
        chk("we", mem_we, (c <= 4) ? tv[v].expWe : 1'b0);
        if (c <= 4) begin
          chk("addr", mem_addr, tv[v].expAddr[(c-1)*32 +: 32]);
          lane = tv[v].expWe ? tv[v].wv[(c-1)*32 +: 32] : 32'h0;
          chk("wdata", mem_wdata, lane);
          chk("stall_busy", stall, 1);
        end
        if (done === 1'b1) begin
          doneAt = c;
          chk("stall_done", stall, 0);
          chk("addr_done", mem_addr, 0);
          chk("wdata_done", mem_wdata, 0);
        end
      end
      chk("latency", doneAt, tv[v].expLat);
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("rvec", rvec, tv[v].expRv);
    end

    // Reset raised during ACCESS lane 2 of a store: only lanes 0,1 written.
    @(negedge clk);
    req = 1'b1; vstore = 1'b1; base = 32'h500; wvec = STV;
    @(posedge clk); #1;
    req = 1'b0; vstore = 1'b0;
    lane = wrCount;
    repeat (3) @(negedge clk);
    reset = 1'b1; #1;
    chk("rst_mid_we", mem_we, 0);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_writes", wrCount - lane, 2);
    chk("abort_we", mem_we, 0);
    chk("abort_addr", mem_addr, 0);
    chk("abort_wdata", mem_wdata, 0);
    chk("abort_done", done, 0);
    chk("abort_stall", stall, 0);
    chk("abort_rvec", rvec, 0);
    @(negedge clk);
    chk("abort_writes_after", wrCount - lane, 2);

    // Back-to-back loads with req held high through DONE.
    req = 1'b1; vload = 1'b1; base = 32'h200; stride = 32'h4;
    doneAt = 0;
    for (int c = 1; c <= 12 && doneAt == 0; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (done === 1'b1) doneAt = c;
    end
    chk("b2b_lat1", doneAt, 6);
    chk("b2b_done_stall", stall, 0);
    @(negedge clk);
    chk("b2b_idle_done", done, 0);
    chk("b2b_idle_stall", stall, 1);
    chk("b2b_idle_addr", mem_addr, 0);
    @(negedge clk);
    req = 1'b0; vload = 1'b0;
    chk("b2b_second_addr", mem_addr, 32'h200);
    doneAt = 0;
    for (int c = 2; c <= 14 && doneAt == 0; c++) begin
      @(negedge clk);
      if (done === 1'b1) doneAt = c;
    end
    chk("b2b_lat2", doneAt, 6);
    chk("b2b_rvec", rvec, LDVEC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
